// File: rtl/psum_replay_src_if.sv
// -----------------------------------------------------------------------------
// psum_replay_src_if
// Partial-sum val/rdy channel from the global buffer (GB) to a PEB.
//   GBPSUM_val  : word valid, driven by the source
//   GBPSUM_data : LANES*PSUM_WIDTH payload, lane i at [PSUM_WIDTH*i +: PSUM_WIDTH]
//   PSUMGB_rdy  : PEB accepts the word, driven by the sink
// Modports: master = psum source (GB side), slave = psum sink (PEB side).
// -----------------------------------------------------------------------------
interface psum_replay_src_if #(
    parameter int LANES      = 16,
    parameter int PSUM_WIDTH = 32
);
    logic                        GBPSUM_val;
    logic [LANES*PSUM_WIDTH-1:0] GBPSUM_data;
    logic                        PSUMGB_rdy;

    modport master (
        output GBPSUM_val,
        output GBPSUM_data,
        input  PSUMGB_rdy
    );

    modport slave (
        input  GBPSUM_val,
        input  GBPSUM_data,
        output PSUMGB_rdy
    );
endinterface

// File: rtl/psum_replay_src.sv
// -----------------------------------------------------------------------------
// psum_replay_src
// Replays a preloaded sequence of 16-lane psum words onto the GB->PEB psum
// val/rdy channel, one word per handshake. Usable as a bench stimulus engine
// or as an on-chip BIST psum source.
//
// Ports:
//   Clk, Rst         : clock, asynchronous active-high reset
//   WrEn/WrAddr/WrData : synchronous write port into the replay store
//   Start, NumWords  : begin a replay of NumWords words (sampled on Start)
//   psum (master)    : GBPSUM_val / GBPSUM_data out, PSUMGB_rdy in
//   Busy             : replay in progress
//   Done             : one-cycle pulse at end of replay
//   BeatCnt          : handshakes completed in the current or last replay
//
// Build option: define PSUM_REPLAY_THROTTLE_EN to gate val with an LFSR after
// every non-last handshake (random bubbles, same order and content).
// -----------------------------------------------------------------------------
module psum_replay_src #(
    parameter int          LANES      = 16,
    parameter int          PSUM_WIDTH = 32,
    parameter int          DEPTH      = 256,
    parameter int          ADDR_WIDTH = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        WrEn,
    input  logic [ADDR_WIDTH-1:0]       WrAddr,
    input  logic [LANES*PSUM_WIDTH-1:0] WrData,
    input  logic                        Start,
    input  logic [ADDR_WIDTH:0]         NumWords,
    psum_replay_src_if.master           psum,
    output logic                        Busy,
    output logic                        Done,
    output logic [ADDR_WIDTH:0]         BeatCnt
);
    localparam int WORD_W = LANES * PSUM_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = (ADDR_WIDTH+1)'(0);
    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = ADDR_WIDTH'(0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_SEND    = 3'd2,
        ST_PENDING = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    logic [WORD_W-1:0]     mem_r [0:DEPTH-1];

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] ptr_r, ptr_s;
    logic [ADDR_WIDTH:0]   num_r, num_s;
    logic [ADDR_WIDTH:0]   beat_r, beat_s;
    logic                  val_r, val_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic [WORD_W-1:0]     data_r;
    logic                  load_s;
    logic [ADDR_WIDTH-1:0] fetch_addr_s;
    logic                  hs_s;
    logic                  gate_s;

    // Handshake only counts while a word is actually offered.
    assign hs_s = val_r & psum.PSUMGB_rdy;

`ifdef PSUM_REPLAY_THROTTLE_EN
    logic [15:0] lfsr_r;
    logic        lfsr_fb_s;

    // Fibonacci feedback, taps 16,14,13,11 (bit indices 15,13,12,10).
    assign lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
    assign gate_s    = lfsr_r[0];

    // Throttle LFSR: free-runs only while a replay is in progress.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            lfsr_r <= LFSR_SEED;
        end else if (busy_r) begin
            lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end
`else
    assign gate_s = 1'b1;
`endif

    // Replay store: written at any time, never reset.
    always_ff @(posedge Clk) begin
        if (WrEn) begin
            mem_r[WrAddr] <= WrData;
        end
    end

    // Payload register: reads the store before this edge's write lands, so a
    // same-address write/fetch returns old data and an offered word is frozen.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            data_r <= '0;
        end else if (load_s) begin
            data_r <= mem_r[fetch_addr_s];
        end else begin
            data_r <= data_r;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= PTR_ZERO;
            num_r   <= CNT_ZERO;
            beat_r  <= CNT_ZERO;
            val_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            num_r   <= num_s;
            beat_r  <= beat_s;
            val_r   <= val_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s      = state_r;
        ptr_s        = ptr_r;
        num_s        = num_r;
        beat_s       = beat_r;
        val_s        = val_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        load_s       = 1'b0;
        fetch_addr_s = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    beat_s = CNT_ZERO;
                    if (NumWords != CNT_ZERO) begin
                        num_s  = (NumWords > CNT_DEPTH) ? CNT_DEPTH : NumWords;
                        ptr_s  = PTR_ZERO;
                        busy_s = 1'b1;
                        state_s = ST_FETCH;
                    end else begin
                        // Empty replay: straight to the Done pulse, Busy stays low.
                        done_s  = 1'b1;
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                load_s  = 1'b1;
                val_s   = 1'b1;
                state_s = ST_SEND;
            end
            ST_SEND: begin
                if (hs_s) begin
                    beat_s = beat_r + CNT_ONE;
                    if (beat_r == (num_r - CNT_ONE)) begin
                        val_s   = 1'b0;
                        done_s  = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        // Next word is loaded on the same edge as the handshake.
                        ptr_s        = ptr_r + PTR_ONE;
                        fetch_addr_s = ptr_r + PTR_ONE;
                        load_s       = 1'b1;
                        val_s        = gate_s;
                        state_s      = gate_s ? ST_SEND : ST_PENDING;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_PENDING: begin
                // Word already loaded; wait for the throttle gate to open.
                if (gate_s) begin
                    val_s   = 1'b1;
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_PENDING;
                end
            end
            ST_DONE: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                val_s   = 1'b0;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    assign psum.GBPSUM_val  = val_r;
    assign psum.GBPSUM_data = data_r;
    assign Busy             = busy_r;
    assign Done             = done_r;
    assign BeatCnt          = beat_r;

endmodule
